fft_frame_sink: RTL
===================

Name: fft_frame_sink

Overview:
- AXI4-Stream slave that terminates the output stream of the radix-4 FFT (k_fixed4fft master side).
- Captures one full transform frame into an internal buffer, optionally reordering digit-reversed FFT output into natural bin order.
- Checks frame framing via tlast and exposes the stored frame to a host/bench through a synchronous read port with explicit release handshake.

Parameters:
- STAGE_NO, 5, number of radix-4 stages; transform length N = 4**STAGE_NO.
- DATA_W, 16, sample width in bits.
- Derived localparams: N = 4**STAGE_NO; ADDR_W = 2*STAGE_NO.

Ports:
- aclk  in  1  single clock, rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- s_axis_data_tdata  in  DATA_W  FFT output sample.
- s_axis_data_tvalid  in  1  sample valid.
- s_axis_data_tready  out  1  sink ready.
- s_axis_data_tlast  in  1  last sample of frame.
- rd_en  in  1  buffer read strobe.
- rd_addr  in  ADDR_W  buffer read address (bin index).
- rd_data  out  DATA_W  read data, registered.
- frame_done  out  1  level; complete frame held in buffer.
- frame_ack  in  1  host releases buffer.
- event_tlast_unexpected  out  1  one-cycle pulse.
- event_tlast_missing  out  1  one-cycle pulse.

Behaviour:
- Reset values: s_axis_data_tready=0, frame_done=0, rd_data=0, both event outputs 0. State=FILL, cnt=0. Buffer contents are not reset.
- States: FILL, HOLD.
- FILL: tready=1 from the first cycle after reset deassertion. On handshake (tvalid&tready), write tdata to mem[waddr(cnt)] and increment cnt (ADDR_W bits).
- Handshake with cnt==N-1:
  - tlast=1: normal end; go to HOLD.
  - tlast=0: pulse event_tlast_missing the next cycle; still go to HOLD.
  - cnt wraps to 0 in both cases.
- Handshake with tlast=1 and cnt<N-1: pulse event_tlast_unexpected the next cycle; cnt=0; stay in FILL. The partial frame is discarded and frame_done is not asserted.
- HOLD: tready=0; frame_done=1. The upstream stalls with tvalid held, and no sample is lost. When frame_ack=1, return to FILL next cycle (frame_done=0, tready=1).
- frame_ack in FILL is ignored.
- Read port:
  - rd_data = mem[rd_addr] one cycle after rd_en=1; otherwise rd_data holds its value.
  - Reads are legal in any state; data is only guaranteed frame-consistent in HOLD.
  - rd_en and frame_ack in the same cycle: the read returns the held frame data, because no write can occur before the following cycle.
- Reset mid-frame: immediate return to FILL with cnt=0; the partial frame is abandoned.
- Memory: N x DATA_W, one write port and one read port, inferable as simple dual-port block RAM.

Optional Feature:
- Macro: FFT_SINK_DIGIT_REVERSE_EN.
- Defined: waddr(cnt) = base-4 digit reversal of cnt. The 2-bit digit pairs of cnt are reversed in order, so digit d_i moves to position STAGE_NO-1-i. rd_addr k then returns bin k in natural order.
- Undefined: waddr(cnt) = cnt (arrival order).
- Reversal is pure wiring; it adds zero latency.

Decomposition:
- Package fft_sink_pkg:
  - typedef sink_state_t {FILL, HOLD}.
  - function digit_rev4(addr, stages).
  - helper localparam computation for N/ADDR_W.
- One sub-module: fft_sink_ram (simple dual-port N x DATA_W, registered read).
- FSM, counter and event logic stay in the top level.

Test Plan:
- Normal frame: N=1024 ramp samples 0..1023 with tlast on the 1024th. Expect frame_done=1 the cycle after the last handshake, then tready=0.
  - Macro defined: rd_addr 256 -> 1, rd_addr 64 -> 4, rd_addr 1023 -> 1023.
  - Macro undefined: rd_addr k -> k.
- Early tlast on sample index 10 -> event_tlast_unexpected pulses once and frame_done stays 0. A following clean 1024-sample frame is captured with sample 0 at address 0.
- No tlast on sample 1023 -> event_tlast_missing pulses once and frame_done=1. The buffer holds all 1024 samples.
- Backpressure: tvalid held high with value 0x7FFF during HOLD for 50 cycles -> no writes and the buffer is unchanged. After frame_ack, 0x7FFF lands at waddr(0)=0.
- Reset asserted after 500 samples -> all outputs 0 and tready=0 during reset. After release, a full frame is captured correctly with no stale count.
- rd_en and frame_ack in the same cycle in HOLD -> rd_data returns the held value, and FILL resumes the next cycle.

Source files
------------

// File: rtl/fft_sink_pkg.sv
// fft_sink_pkg
// Shared types and helpers for the FFT frame sink.
//   sink_state_t : capture FSM states (FILL collects samples, HOLD exposes them)
//   fft_len      : transform length for a given number of radix-4 stages
//   fft_addr_w   : buffer address width for a given number of stages
//   digit_rev4   : base-4 digit reversal used to put FFT output in natural order
package fft_sink_pkg;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } sink_state_t;

   function automatic int fft_len(input int stages);
      return 4 ** stages;
   endfunction

   function automatic int fft_addr_w(input int stages);
      return 2 * stages;
   endfunction

   // Digit i (bits 2i+1:2i) of addr moves to digit position stages-1-i.
   // Only constant indexing after unrolling, so this is pure wiring.
   function automatic logic [31:0] digit_rev4(input logic [31:0] addr,
                                              input int stages);
      logic [31:0] rev;
      rev = '0;
      for (int i = 0; i < stages; i++) begin
         rev[2*(stages-1-i) +: 2] = addr[2*i +: 2];
      end
      return rev;
   endfunction

endpackage

// File: rtl/fft_sink_ram.sv
// fft_sink_ram
// Simple dual-port N x DATA_W buffer: one write port, one registered read port.
// The data array has no reset so it maps onto block RAM; only the read
// register is reset so rd_data comes up as zero.
//   clk, rst_n      : clock, asynchronous active-low reset (read register only)
//   we, waddr, wdata: write port
//   re, raddr       : read strobe and address
//   rdata           : registered read data, holds when re is low
module fft_sink_ram #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // A read that collides with a write returns the old contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (re) begin
         rdata_q <= mem[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/fft_frame_sink.sv
// fft_frame_sink
// AXI4-Stream slave terminating the radix-4 FFT output. Captures one frame of
// N = 4**STAGE_NO samples, checks tlast framing, then holds the frame for the
// host until frame_ack releases it.
// Build option: define FFT_SINK_DIGIT_REVERSE_EN to store samples at the
// base-4 digit-reversed address so rd_addr k returns bin k in natural order;
// otherwise samples are stored in arrival order.
// Ports:
//   aclk, aresetn           : clock, asynchronous active-low reset
//   s_axis_data_*           : incoming FFT sample stream (tready registered)
//   rd_en, rd_addr, rd_data : buffer read port, data one cycle after rd_en
//   frame_done              : level, a complete frame sits in the buffer
//   frame_ack               : host releases the buffer (ignored while filling)
//   event_tlast_unexpected  : pulse, tlast before the last sample (frame dropped)
//   event_tlast_missing     : pulse, last sample arrived without tlast
module fft_frame_sink
   import fft_sink_pkg::*;
#(
   parameter int STAGE_NO = 5,
   parameter int DATA_W   = 16
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   input  logic [DATA_W-1:0]             s_axis_data_tdata,
   input  logic                          s_axis_data_tvalid,
   output logic                          s_axis_data_tready,
   input  logic                          s_axis_data_tlast,
   input  logic                          rd_en,
   input  logic [fft_addr_w(STAGE_NO)-1:0] rd_addr,
   output logic [DATA_W-1:0]             rd_data,
   output logic                          frame_done,
   input  logic                          frame_ack,
   output logic                          event_tlast_unexpected,
   output logic                          event_tlast_missing
);

   localparam int N      = fft_len(STAGE_NO);
   localparam int ADDR_W = fft_addr_w(STAGE_NO);
   localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(N - 1);

   sink_state_t       state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              tready_q, tready_d;
   logic              frame_done_q, frame_done_d;
   logic              unexpected_q, unexpected_d;
   logic              missing_q, missing_d;

   logic              handshake;
   logic [ADDR_W-1:0] waddr;

   assign handshake = s_axis_data_tvalid & tready_q;

`ifdef FFT_SINK_DIGIT_REVERSE_EN
   assign waddr = ADDR_W'(digit_rev4(32'(cnt_q), STAGE_NO));
`else
   assign waddr = cnt_q;
`endif

   // Next-state logic. tready and frame_done are computed one cycle ahead so
   // they leave the block straight from flops: tready drops on the same edge
   // that accepts the last sample, so the upstream simply stalls in HOLD.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      tready_d     = 1'b0;
      frame_done_d = 1'b0;
      unexpected_d = 1'b0;
      missing_d    = 1'b0;
      case (state_q)
         FILL: begin
            tready_d = 1'b1;
            if (handshake) begin
               if (cnt_q == LAST_CNT) begin
                  cnt_d        = '0;
                  state_d      = HOLD;
                  tready_d     = 1'b0;
                  frame_done_d = 1'b1;
                  missing_d    = ~s_axis_data_tlast;
               end else if (s_axis_data_tlast) begin
                  // Short frame: discard it and restart from bin 0.
                  cnt_d        = '0;
                  unexpected_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         HOLD: begin
            frame_done_d = 1'b1;
            if (frame_ack) begin
               state_d      = FILL;
               tready_d     = 1'b1;
               frame_done_d = 1'b0;
            end
         end
         default: begin
            state_d = FILL;
            cnt_d   = '0;
         end
      endcase
   end

   // Capture FSM, sample counter and registered status outputs.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q      <= FILL;
         cnt_q        <= '0;
         tready_q     <= 1'b0;
         frame_done_q <= 1'b0;
         unexpected_q <= 1'b0;
         missing_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         tready_q     <= tready_d;
         frame_done_q <= frame_done_d;
         unexpected_q <= unexpected_d;
         missing_q    <= missing_d;
      end
   end

   fft_sink_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (aclk),
      .rst_n (aresetn),
      .we    (handshake),
      .waddr (waddr),
      .wdata (s_axis_data_tdata),
      .re    (rd_en),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   assign s_axis_data_tready     = tready_q;
   assign frame_done             = frame_done_q;
   assign event_tlast_unexpected = unexpected_q;
   assign event_tlast_missing    = missing_q;

endmodule
